// File: rtl/mem_port_arbiter.sv
// Serialises lane A then lane B loads/stores onto the single data-memory port, stalling MEM until both retire.
// Optional MEM_ARB_FWD_EN: forward a lane-A store to a same-word lane-B load without a second memory access.
module mem_port_arbiter #(
  parameter int DATA_WIDTH  = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            a_op,
  input  logic [DATA_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  input  logic [1:0]            b_op,
  input  logic [DATA_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  stall,
  output logic [3:0]            haz,
  output logic [DATA_WIDTH-1:0] a_rdata,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic                  mem_err,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ_A, S_WAIT_A, S_REQ_B, S_WAIT_B, S_DONE
  } state_t;

  localparam logic [3:0] HAZ_A_STALL = 4'd0;
  localparam logic [3:0] HAZ_B_STALL = 4'd1;
  localparam logic [3:0] HAZ_NONE    = 4'd9;
  localparam int         CNT_W       = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_t                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_busy;
  logic [3:0]            r_haz;
  logic                  r_req;
  logic                  r_we;
  logic [DATA_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_a_rdata;
  logic [DATA_WIDTH-1:0] r_b_rdata;
  logic                  r_err;

  logic   w_a_ld, w_a_st, w_a_act;
  logic   w_b_ld, w_b_st, w_b_act;
  logic   w_fwd;
  logic   w_tmo;
  logic   w_tmo_hit;
  logic   w_a_fin;
  logic   w_b_fin;
  state_t w_nxt;

  assign w_a_ld  = (a_op == 2'b01);
  assign w_a_st  = (a_op == 2'b10);
  assign w_a_act = w_a_ld | w_a_st;
  assign w_b_ld  = (b_op == 2'b01);
  assign w_b_st  = (b_op == 2'b10);
  assign w_b_act = w_b_ld | w_b_st;
  assign w_tmo   = (r_cnt == TMO_LAST);

`ifdef MEM_ARB_FWD_EN
  assign w_fwd = w_a_st & w_b_ld &
                 (a_addr[DATA_WIDTH-1:2] == b_addr[DATA_WIDTH-1:2]);
`else
  assign w_fwd = 1'b0;
`endif

  // A lane "finishes" on store grant, load data return, or timeout; gnt wins over a same-cycle timeout.
  always_comb begin
    w_nxt     = r_state;
    w_a_fin   = 1'b0;
    w_b_fin   = 1'b0;
    w_tmo_hit = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_a_act)      w_nxt = S_REQ_A;
        else if (w_b_act) w_nxt = S_REQ_B;
      end
      S_REQ_A: begin
        if (mem_gnt) begin
          if (w_a_ld) w_nxt = S_WAIT_A;
          else        w_a_fin = 1'b1;
        end else if (w_tmo) begin
          w_a_fin   = 1'b1;
          w_tmo_hit = 1'b1;
        end
      end
      S_WAIT_A: begin
        if (mem_rvalid) begin
          w_a_fin = 1'b1;
        end else if (w_tmo) begin
          w_a_fin   = 1'b1;
          w_tmo_hit = 1'b1;
        end
      end
      S_REQ_B: begin
        if (mem_gnt) begin
          if (w_b_ld) w_nxt = S_WAIT_B;
          else        w_b_fin = 1'b1;
        end else if (w_tmo) begin
          w_b_fin   = 1'b1;
          w_tmo_hit = 1'b1;
        end
      end
      S_WAIT_B: begin
        if (mem_rvalid) begin
          w_b_fin = 1'b1;
        end else if (w_tmo) begin
          w_b_fin   = 1'b1;
          w_tmo_hit = 1'b1;
        end
      end
      S_DONE:  w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
    if (w_a_fin) w_nxt = (w_b_act && !w_fwd) ? S_REQ_B : S_DONE;
    if (w_b_fin) w_nxt = S_DONE;
  end

  // Port-facing outputs are registered from the next state so they are valid for the whole state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_haz     <= HAZ_NONE;
      r_req     <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_a_rdata <= '0;
      r_b_rdata <= '0;
      r_err     <= 1'b0;
    end else begin
      r_state <= w_nxt;
      if (w_nxt != r_state)
        r_cnt <= '0;
      else if (r_state != S_IDLE && r_state != S_DONE)
        r_cnt <= r_cnt + CNT_W'(1);

      r_busy <= (w_nxt == S_REQ_A) || (w_nxt == S_WAIT_A) ||
                (w_nxt == S_REQ_B) || (w_nxt == S_WAIT_B);
      r_req  <= (w_nxt == S_REQ_A) || (w_nxt == S_REQ_B);
      r_we   <= ((w_nxt == S_REQ_A) && w_a_st) || ((w_nxt == S_REQ_B) && w_b_st);

      if ((w_nxt == S_REQ_A) || (w_nxt == S_WAIT_A))      r_haz <= HAZ_A_STALL;
      else if ((w_nxt == S_REQ_B) || (w_nxt == S_WAIT_B)) r_haz <= HAZ_B_STALL;
      else                                                r_haz <= HAZ_NONE;

      if (w_nxt == S_REQ_A) begin
        r_addr  <= a_addr;
        r_wdata <= a_wdata;
      end else if (w_nxt == S_REQ_B) begin
        r_addr  <= b_addr;
        r_wdata <= b_wdata;
      end

      if (r_state == S_WAIT_A && mem_rvalid) r_a_rdata <= mem_rdata;
      else if (w_a_fin && w_tmo_hit)         r_a_rdata <= '0;

      if (r_state == S_WAIT_B && mem_rvalid) r_b_rdata <= mem_rdata;
      else if (w_b_fin && w_tmo_hit)         r_b_rdata <= '0;
      else if (w_a_fin && w_fwd)             r_b_rdata <= a_wdata;

      if (w_tmo_hit) r_err <= 1'b1;
    end
  end

  assign stall     = r_busy | ((r_state == S_IDLE) & (w_a_act | w_b_act));
  assign haz       = r_haz;
  assign mem_req   = r_req;
  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign a_rdata   = r_a_rdata;
  assign b_rdata   = r_b_rdata;
  assign mem_err   = r_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: cycle-by-cycle vector table plus timeout and reset sequences.
module tb_mem_port_arbiter;

  localparam logic [1:0]  N  = 2'b00;
  localparam logic [1:0]  L  = 2'b01;
  localparam logic [1:0]  S  = 2'b10;
  localparam logic [31:0] BW = 32'hB0B0_0000;
  localparam logic [31:0] D  = 32'hDEAD_BEEF;
  localparam logic [31:0] C  = 32'hCAFE_0003;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  a_op, b_op;
  logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
  logic        stall, mem_err, mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [3:0]  haz;
  logic [31:0] a_rdata, b_rdata, mem_addr, mem_wdata, mem_rdata;

  int n_cmp  = 0;
  int n_fail = 0;

  mem_port_arbiter #(.DATA_WIDTH(32), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst(rst),
    .a_op(a_op), .a_addr(a_addr), .a_wdata(a_wdata),
    .b_op(b_op), .b_addr(b_addr), .b_wdata(b_wdata),
    .stall(stall), .haz(haz), .a_rdata(a_rdata), .b_rdata(b_rdata),
    .mem_err(mem_err), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  aop;
    logic [31:0] aaddr, awd;
    logic [1:0]  bop;
    logic [31:0] baddr;
    logic        gnt, rv;
    logic [31:0] rdata;
    logic        stall;
    logic [3:0]  haz;
    logic        req, we;
    logic [31:0] addr, wdata, ard, brd;
    logic        err;
  } vec_t;

  vec_t q[$];

  task automatic add(input logic [1:0] aop, input logic [31:0] aaddr, input logic [31:0] awd,
                     input logic [1:0] bop, input logic [31:0] baddr,
                     input logic gnt, input logic rv, input logic [31:0] rdata,
                     input logic e_stall, input logic [3:0] e_haz, input logic e_req, input logic e_we,
                     input logic [31:0] e_addr, input logic [31:0] e_wdata,
                     input logic [31:0] e_ard, input logic [31:0] e_brd, input logic e_err);
    vec_t v;
    v.aop = aop; v.aaddr = aaddr; v.awd = awd; v.bop = bop; v.baddr = baddr;
    v.gnt = gnt; v.rv = rv; v.rdata = rdata;
    v.stall = e_stall; v.haz = e_haz; v.req = e_req; v.we = e_we;
    v.addr = e_addr; v.wdata = e_wdata; v.ard = e_ard; v.brd = e_brd; v.err = e_err;
    q.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; a_op = N; b_op = N; a_addr = '0; a_wdata = '0;
    b_addr = '0; b_wdata = BW; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;

    // idle bundle after reset
    repeat (3) add(N,0,0, N,0, 0,0,0,  0,9,0,0, 0,0,0,0,0);
    // lane A load 0x100
    add(L,32'h100,0, N,0, 0,0,0,  1,9,0,0, 0,0,0,0,0);
    add(L,32'h100,0, N,0, 1,0,0,  1,0,1,0, 32'h100,0,0,0,0);
    add(L,32'h100,0, N,0, 0,1,D,  1,0,0,0, 32'h100,0,0,0,0);
    add(N,0,0, N,0, 0,0,0,        0,9,0,0, 32'h100,0,D,0,0);
    add(N,0,0, N,0, 0,0,0,        0,9,0,0, 32'h100,0,D,0,0);
    // A store 0x200<-0x11, B load 0x300, gnt delayed two cycles; stray gnt/rvalid ignored
    add(S,32'h200,32'h11, L,32'h300, 1,0,0,        1,9,0,0, 32'h100,0,D,0,0);
    add(S,32'h200,32'h11, L,32'h300, 0,0,0,        1,0,1,1, 32'h200,32'h11,D,0,0);
    add(S,32'h200,32'h11, L,32'h300, 0,0,0,        1,0,1,1, 32'h200,32'h11,D,0,0);
    add(S,32'h200,32'h11, L,32'h300, 1,0,0,        1,0,1,1, 32'h200,32'h11,D,0,0);
    add(S,32'h200,32'h11, L,32'h300, 0,1,32'hBAD,  1,1,1,0, 32'h300,BW,D,0,0);
    add(S,32'h200,32'h11, L,32'h300, 0,0,0,        1,1,1,0, 32'h300,BW,D,0,0);
    add(S,32'h200,32'h11, L,32'h300, 1,0,0,        1,1,1,0, 32'h300,BW,D,0,0);
    add(S,32'h200,32'h11, L,32'h300, 0,1,C,        1,1,0,0, 32'h300,BW,D,0,0);
    add(N,0,0, N,0, 0,0,0,                         0,9,0,0, 32'h300,BW,D,C,0);
    add(N,0,0, N,0, 0,0,0,                         0,9,0,0, 32'h300,BW,D,C,0);
    // A store 0x400<-0x55, B load 0x404 (same word)
    add(S,32'h400,32'h55, L,32'h404, 0,0,0,        1,9,0,0, 32'h300,BW,D,C,0);
    add(S,32'h400,32'h55, L,32'h404, 1,0,0,        1,0,1,1, 32'h400,32'h55,D,C,0);
`ifdef MEM_ARB_FWD_EN
    add(N,0,0, N,0, 0,0,0,                         0,9,0,0, 32'h400,32'h55,D,32'h55,0);
    add(N,0,0, N,0, 0,0,0,                         0,9,0,0, 32'h400,32'h55,D,32'h55,0);
`else
    add(S,32'h400,32'h55, L,32'h404, 1,0,0,        1,1,1,0, 32'h404,BW,D,C,0);
    add(S,32'h400,32'h55, L,32'h404, 0,1,32'h77,   1,1,0,0, 32'h404,BW,D,C,0);
    add(N,0,0, N,0, 0,0,0,                         0,9,0,0, 32'h404,BW,D,32'h77,0);
    add(N,0,0, N,0, 0,0,0,                         0,9,0,0, 32'h404,BW,D,32'h77,0);
`endif

    repeat (2) @(posedge clk);
    foreach (q[i]) begin
      @(negedge clk);
      rst = 1'b0;
      a_op = q[i].aop; a_addr = q[i].aaddr; a_wdata = q[i].awd;
      b_op = q[i].bop; b_addr = q[i].baddr;
      mem_gnt = q[i].gnt; mem_rvalid = q[i].rv; mem_rdata = q[i].rdata;
      #1;
      n_cmp++;
      if ({stall, haz, mem_req, mem_we, mem_addr, mem_wdata, a_rdata, b_rdata, mem_err} !==
          {q[i].stall, q[i].haz, q[i].req, q[i].we, q[i].addr, q[i].wdata, q[i].ard, q[i].brd, q[i].err}) begin
        n_fail++;
        $display("FAIL vec%0d: got stall=%0b haz=%0d req=%0b we=%0b addr=%0h wd=%0h ard=%0h brd=%0h err=%0b expected stall=%0b haz=%0d req=%0b we=%0b addr=%0h wd=%0h ard=%0h brd=%0h err=%0b",
                 i, stall, haz, mem_req, mem_we, mem_addr, mem_wdata, a_rdata, b_rdata, mem_err,
                 q[i].stall, q[i].haz, q[i].req, q[i].we, q[i].addr, q[i].wdata, q[i].ard, q[i].brd, q[i].err);
      end
    end

    // lane A load with gnt held low: 16 REQ_A cycles then timeout
    @(negedge clk);
    a_op = L; a_addr = 32'h500; b_op = N; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    #1 chk("tmo_idle_stall", 32'(stall), 32'd1);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk); #1;
      chk($sformatf("tmo_req_c%0d", k), {28'd0, haz[0], mem_req, mem_err, stall}, {28'd0, 1'b0, 1'b1, 1'b0, 1'b1});
    end
    @(negedge clk); #1;
    chk("tmo_done_err", 32'(mem_err), 32'd1);
    chk("tmo_done_ard", a_rdata, 32'd0);
    chk("tmo_done_stall", 32'(stall), 32'd0);
    chk("tmo_done_haz", 32'(haz), 32'd9);
    a_op = N;
    repeat (3) @(negedge clk);
    #1 chk("tmo_err_sticky", 32'(mem_err), 32'd1);

    // reset while waiting for lane B read data
    @(negedge clk);
    b_op = L; b_addr = 32'h600;
    #1 chk("rstb_idle_stall", 32'(stall), 32'd1);
    @(negedge clk);
    mem_gnt = 1'b1;
    #1 chk("rstb_req", {28'd0, haz}, 32'd1);
    chk("rstb_req_addr", mem_addr, 32'h600);
    @(negedge clk);
    mem_gnt = 1'b0; rst = 1'b1;
    #1 chk("rstb_wait", {30'd0, mem_req, stall}, 32'd1);
    @(negedge clk);
    rst = 1'b0; b_op = N; mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
    #1;
    chk("rstb_state", {22'd0, stall, haz, mem_req, mem_we, mem_err}, {22'd0, 1'b0, 4'd9, 1'b0, 1'b0, 1'b0});
    chk("rstb_addr", mem_addr, 32'd0);
    chk("rstb_ard", a_rdata, 32'd0);
    chk("rstb_brd", b_rdata, 32'd0);
    @(negedge clk);
    mem_rvalid = 1'b0;
    #1 chk("rstb_late_rv", b_rdata, 32'd0);
    chk("rstb_late_state", {27'd0, stall, haz}, 32'd9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
